line_mem_responder: RTL and testbench

Memory-side responder for the cache line-transfer protocol: services 16-word line writebacks (`store`) and line fills (`load`) issued by the cache controller FSM, against an internal word-addressed backing array. It owns the burst word counter `cnt` that the cache controller consumes to detect end of burst (`cnt == 15`). It raises `complete` once a writeback has committed, releasing the controller from its wait-for-writeback state. It sits between the cache controller/datapath and main memory.

---
 rtl/line_mem_responder.sv | 158 +++++++++++++++
 tb/tb_line_mem_responder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : line_mem_responder
// Description : Memory-side responder for 16-word cache line transfers.
//               Services line writebacks (store) and line fills (load)
//               against an internal word-addressed backing array, and owns
//               the burst word counter used by the cache controller.
// Ports       : clk, rst (async, active-low)
//               load, store, line_addr, wdata      -- requests from cache
//               rdata, rvalid                      -- fill data path
//               wready, cnt, complete, busy        -- handshake / status
// Revision    : 1.0 - initial release
// ============================================================================
module line_mem_responder #(
  parameter int AW     = 10,
  parameter int DW     = 32,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          store,
  input  logic [AW-5:0] line_addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          wready,
  output logic [3:0]    cnt,
  output logic          complete,
  output logic          busy
);

  localparam int c_LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int c_LW      = (c_LAT_MAX == 0) ? 1 : $clog2(c_LAT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR_BURST  = 3'd1,
    S_WR_COMMIT = 3'd2,
    S_WR_DONE   = 3'd3,
    S_RD_WAIT   = 3'd4,
    S_RD_BURST  = 3'd5
  } state_t;

  state_t          r_state, w_state_nx;
  logic [3:0]      r_cnt, w_cnt_nx;
  logic [c_LW-1:0] r_lat, w_lat_nx;
  logic [AW-5:0]   r_line_q, w_line_nx;
  logic            w_we;
  logic [AW-1:0]   w_waddr;

  // Backing array is deliberately not reset: a line survives a reset.
  logic [DW-1:0]   r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_lat    <= '0;
      r_line_q <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_lat    <= w_lat_nx;
      r_line_q <= w_line_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= wdata;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_lat_nx   = r_lat;
    w_line_nx  = r_line_q;
    w_we       = 1'b0;
    w_waddr    = {r_line_q, r_cnt};

    case (r_state)
      S_IDLE: begin
        // Store has priority; a coincident load is dropped, not queued.
        if (store) begin
          w_line_nx  = line_addr;
          w_we       = 1'b1;
          w_waddr    = {line_addr, 4'd0};
          w_cnt_nx   = 4'd1;
          w_state_nx = S_WR_BURST;
        end else if (load) begin
          w_line_nx  = line_addr;
          w_cnt_nx   = 4'd0;
          w_lat_nx   = c_LW'(RD_LAT);
          w_state_nx = (RD_LAT == 0) ? S_RD_BURST : S_RD_WAIT;
        end
      end

      S_WR_BURST: begin
        if (store) begin
          w_we     = 1'b1;
          w_cnt_nx = r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            w_lat_nx   = c_LW'(WR_LAT);
            w_state_nx = (WR_LAT == 0) ? S_WR_DONE : S_WR_COMMIT;
          end
        end
      end

      // Latency counter holds the remaining cycles including the current one.
      S_WR_COMMIT: begin
        w_lat_nx = r_lat - c_LW'(1);
        if (r_lat <= c_LW'(1)) begin
          w_lat_nx   = '0;
          w_state_nx = S_WR_DONE;
        end
      end

      S_WR_DONE: begin
        w_state_nx = S_IDLE;
      end

      S_RD_WAIT: begin
        w_lat_nx = r_lat - c_LW'(1);
        if (r_lat <= c_LW'(1)) begin
          w_lat_nx   = '0;
          w_state_nx = S_RD_BURST;
        end
      end

      S_RD_BURST: begin
        if (load) begin
          w_cnt_nx = r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            w_state_nx = S_IDLE;
          end
        end
      end

      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = 4'd0;
        w_lat_nx   = '0;
      end
    endcase
  end

  assign rvalid   = (r_state == S_RD_BURST);
  assign rdata    = rvalid ? r_mem[{r_line_q, r_cnt}] : '0;
  assign wready   = (r_state == S_IDLE) || (r_state == S_WR_BURST);
  assign cnt      = r_cnt;
  assign complete = (r_state == S_WR_DONE);
  assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_line_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_mem_responder
// Description : Self-checking bench for line_mem_responder. Two instances:
//               A with RD_LAT=2/WR_LAT=3, B with zero latencies. A select
//               bit routes stimulus to one instance while the other idles.
//               Expected timing comes from the burst-length formulas and
//               expected data from a word-level memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_mem_responder;

  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sel = 1'b0;
  logic load = 1'b0, store = 1'b0;
  logic [AW-5:0] line_addr = '0;
  logic [DW-1:0] wdata = '0;

  logic load_a, store_a, load_b, store_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic rvalid_a, rvalid_b, wready_a, wready_b;
  logic [3:0] cnt_a, cnt_b;
  logic complete_a, complete_b, busy_a, busy_b;

  logic [DW-1:0] o_rdata;
  logic o_rvalid, o_wready, o_complete, o_busy;
  logic [3:0] o_cnt;

  int nchk = 0;
  int nerr = 0;

  logic [31:0] mdl   [2][1024];
  bit          known [2][1024];

  always #5 clk = ~clk;

  assign load_a  = sel ? 1'b0 : load;
  assign store_a = sel ? 1'b0 : store;
  assign load_b  = sel ? load  : 1'b0;
  assign store_b = sel ? store : 1'b0;

  assign o_rdata    = sel ? rdata_b    : rdata_a;
  assign o_rvalid   = sel ? rvalid_b   : rvalid_a;
  assign o_wready   = sel ? wready_b   : wready_a;
  assign o_cnt      = sel ? cnt_b      : cnt_a;
  assign o_complete = sel ? complete_b : complete_a;
  assign o_busy     = sel ? busy_b     : busy_a;

  line_mem_responder #(.AW(AW), .DW(DW), .RD_LAT(2), .WR_LAT(3)) u_dut_a (
    .clk(clk), .rst(rst), .load(load_a), .store(store_a),
    .line_addr(line_addr), .wdata(wdata), .rdata(rdata_a), .rvalid(rvalid_a),
    .wready(wready_a), .cnt(cnt_a), .complete(complete_a), .busy(busy_a)
  );

  line_mem_responder #(.AW(AW), .DW(DW), .RD_LAT(0), .WR_LAT(0)) u_dut_b (
    .clk(clk), .rst(rst), .load(load_b), .store(store_b),
    .line_addr(line_addr), .wdata(wdata), .rdata(rdata_b), .rvalid(rvalid_b),
    .wready(wready_b), .cnt(cnt_b), .complete(complete_b), .busy(busy_b)
  );

  function automatic int rl();
    return sel ? 0 : 2;
  endfunction

  function automatic int wl();
    return sel ? 0 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},     32'(o_busy),     32'd0);
    chk({tag, "_rvalid"},   32'(o_rvalid),   32'd0);
    chk({tag, "_rdata"},    o_rdata,         32'd0);
    chk({tag, "_wready"},   32'(o_wready),   32'd1);
    chk({tag, "_cnt"},      32'(o_cnt),      32'd0);
    chk({tag, "_complete"}, 32'(o_complete), 32'd0);
  endtask

  // mode: 0 random, 1 all ones, 2 all zeros, 3 0xA000_0000+i
  // stop_at < 16 leaves the burst unfinished after stop_at words.
  task automatic do_write(input int line, input int mode, input bit with_load,
                          input int stop_at, input int pause_at, input int pause_len,
                          input bit rnd);
    logic [31:0] d;
    int np;
    for (int i = 0; i < 16; i++) begin
      if (i == stop_at) return;
      np = 0;
      if (i > 0) begin
        if (i == pause_at) np = pause_len;
        else if (rnd && $urandom_range(0, 4) == 0) np = $urandom_range(1, 3);
      end
      for (int p = 0; p < np; p++) begin
        @(negedge clk);
        chk("wr_pause_cnt",    32'(o_cnt),      32'(i));
        chk("wr_pause_busy",   32'(o_busy),     32'd1);
        chk("wr_pause_wready", 32'(o_wready),   32'd1);
        store = 1'b0;
        load  = 1'($urandom_range(0, 1));
        wdata = $urandom;
      end
      case (mode)
        1:       d = 32'hFFFF_FFFF;
        2:       d = 32'h0;
        3:       d = 32'hA000_0000 + 32'(i);
        default: d = $urandom;
      endcase
      @(negedge clk);
      chk("wr_cnt",      32'(o_cnt),      32'(i));
      chk("wr_busy",     32'(o_busy),     (i > 0) ? 32'd1 : 32'd0);
      chk("wr_wready",   32'(o_wready),   32'd1);
      chk("wr_complete", 32'(o_complete), 32'd0);
      store     = 1'b1;
      wdata     = d;
      line_addr = (i == 0) ? 6'(line) : 6'($urandom);
      load      = (i == 0) ? with_load : 1'($urandom_range(0, 1));
      mdl[sel][line*16+i]   = d;
      known[sel][line*16+i] = 1'b1;
    end
    // Commit window: random requests here must be ignored.
    for (int k = 0; k < wl(); k++) begin
      @(negedge clk);
      chk("commit_busy",     32'(o_busy),     32'd1);
      chk("commit_complete", 32'(o_complete), 32'd0);
      chk("commit_wready",   32'(o_wready),   32'd0);
      chk("commit_cnt",      32'(o_cnt),      32'd0);
      store     = 1'($urandom_range(0, 1));
      load      = 1'($urandom_range(0, 1));
      line_addr = 6'($urandom);
      wdata     = $urandom;
    end
    @(negedge clk);
    chk("done_complete", 32'(o_complete), 32'd1);
    chk("done_busy",     32'(o_busy),     32'd1);
    store = 1'b0;
    load  = 1'b0;
    @(negedge clk);
    chk_idle("post_wr");
  endtask

  task automatic do_read(input int line, input int pause_at, input int pause_len,
                         input bit rnd);
    int np;
    int idx;
    @(negedge clk);
    chk_idle("rd_start");
    load      = 1'b1;
    store     = 1'b0;
    line_addr = 6'(line);
    for (int k = 0; k < rl(); k++) begin
      @(negedge clk);
      chk("rdwait_busy",   32'(o_busy),   32'd1);
      chk("rdwait_rvalid", 32'(o_rvalid), 32'd0);
      chk("rdwait_rdata",  o_rdata,       32'd0);
      chk("rdwait_cnt",    32'(o_cnt),    32'd0);
      load      = 1'($urandom_range(0, 1));
      line_addr = 6'($urandom);
    end
    for (int i = 0; i < 16; i++) begin
      idx = line * 16 + i;
      np = (i == pause_at) ? pause_len :
           ((rnd && $urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0);
      for (int p = 0; p <= np; p++) begin
        @(negedge clk);
        chk("rd_rvalid", 32'(o_rvalid), 32'd1);
        chk("rd_cnt",    32'(o_cnt),    32'(i));
        chk("rd_busy",   32'(o_busy),   32'd1);
        chk("rd_wready", 32'(o_wready), 32'd0);
        if (known[sel][idx]) chk("rd_data", o_rdata, mdl[sel][idx]);
        load      = (p == np) ? 1'b1 : 1'b0;
        line_addr = 6'($urandom);
      end
    end
    @(negedge clk);
    chk_idle("post_rd");
    load = 1'b0;
  endtask

  initial begin
    int ln;
    int written [$];
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 1024; a++) known[s][a] = 1'b0;

    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b1;

    // Directed writeback/fill of line 5 with A000_0000+i.
    do_write(5, 3, 1'b0, 16, -1, 0, 1'b0);
    do_read(5, -1, 0, 1'b0);

    // Directed pauses.
    do_write(6, 0, 1'b0, 16, 4, 3, 1'b0);
    do_read(6, 9, 2, 1'b0);

    // Simultaneous load+store: writeback wins, load is not remembered.
    do_write(7, 0, 1'b1, 16, -1, 0, 1'b0);
    @(negedge clk);
    chk_idle("no_pending_load");
    do_read(7, -1, 0, 1'b0);

    // Line isolation.
    do_write(0, 1, 1'b0, 16, -1, 0, 1'b0);
    do_write(63, 2, 1'b0, 16, -1, 0, 1'b0);
    do_read(0, -1, 0, 1'b0);
    do_read(63, -1, 0, 1'b0);
    do_read(5, -1, 0, 1'b0);

    // Randomized traffic.
    written = '{0, 5, 6, 7, 63};
    for (int n = 0; n < 6; n++) begin
      ln = $urandom_range(8, 62);
      written.push_back(ln);
      do_write(ln, 0, 1'($urandom_range(0, 1)), 16, -1, 0, 1'b1);
      do_read(written[$urandom_range(0, written.size() - 1)], -1, 0, 1'b1);
    end

    // Reset mid-writeback at cnt=7; words 0..6 of line 20 must survive.
    for (int i = 0; i < 16; i++) known[0][20*16+i] = 1'b0;
    do_write(20, 0, 1'b0, 7, -1, 0, 1'b0);
    @(negedge clk);
    chk("pre_rst_cnt", 32'(o_cnt), 32'd7);
    store = 1'b1;
    wdata = $urandom;
    #2 rst = 1'b0;
    #1;
    chk_idle("mid_rst");
    @(negedge clk);
    store = 1'b0;
    rst   = 1'b1;
    do_read(20, -1, 0, 1'b0);

    // Zero-latency instance.
    sel = 1'b1;
    do_write(9, 3, 1'b0, 16, -1, 0, 1'b0);
    do_read(9, -1, 0, 1'b0);
    do_write(10, 0, 1'b1, 16, 5, 2, 1'b1);
    do_read(10, 3, 1, 1'b1);
    do_read(9, -1, 0, 1'b1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
`default_nettype wire
